// File: rtl/pic_cpu_if_pkg.sv
// Shared types and constants for the 8259A CPU-side bus initiator.
// Optional feature macro: PIC_CPU_IF_INT_SYNC_EN (2-flop INT synchronizer).
package pic_cpu_if_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_GAP,
      ST_INTA_LOW,
      ST_INTA_GAP
   } state_e;

   localparam int         INTA_PULSES_8086 = 2;
   localparam int         INTA_PULSES_8080 = 3;
   localparam logic [7:0] CALL_OPCODE      = 8'hCD;

   // Index of the final INTA pulse for the selected CPU mode.
   function automatic logic [1:0] last_pulse_idx(input logic mode_8086);
      return mode_8086 ? 2'(INTA_PULSES_8086 - 1) : 2'(INTA_PULSES_8080 - 1);
   endfunction

endpackage

// File: rtl/pic_strobe_timer.sv
// Phase timer for the PIC bus initiator: a down-counter loaded with a phase
// length; done is high during the last clock of the phase.
module pic_strobe_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: reload on request, otherwise count down to zero and stop.
   always_comb begin
      // NOTE: default assignment first so no branch leaves count_d unassigned (no latch).
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for state so every flop samples pre-edge values.
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == W'(1));

endmodule

// File: rtl/pic_cpu_interface.sv
// CPU-side bus initiator for the 8259A PIC: runs ICW/OCW write and status read
// cycles from a valid/ready command port and answers INT with a full INTA
// pulse sequence, capturing the returned vector.
// Optional feature macro: PIC_CPU_IF_INT_SYNC_EN -- INT passes through a
// 2-flop synchronizer (2 clocks of extra INT-to-decision latency).
module pic_cpu_interface
   import pic_cpu_if_pkg::*;
#(
   parameter int STROBE_CYCLES = 2,
   parameter int GAP_CYCLES    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic        cmd_a0,
   input  logic [7:0]  cmd_data,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   input  logic        int_ack_en,
   input  logic        mode_8086,
   input  logic        INT,
   output logic        INTA,
   output logic        RD,
   output logic        WR,
   output logic        CS,
   output logic        A0,
   output logic [7:0]  data_out,
   output logic        data_oe,
   input  logic [7:0]  data_in,
   output logic        ack_valid,
   output logic [15:0] ack_data,
   output logic        ack_err
);

   localparam int MAX_CYCLES = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   state_e      state_q,     state_d;
   logic        cs_n_q,      cs_n_d;
   logic        rd_n_q,      rd_n_d;
   logic        wr_n_q,      wr_n_d;
   logic        inta_n_q,    inta_n_d;
   logic        a0_q,        a0_d;
   logic [7:0]  data_out_q,  data_out_d;
   logic        data_oe_q,   data_oe_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [7:0]  rsp_data_q,  rsp_data_d;
   logic        ack_valid_q, ack_valid_d;
   logic [15:0] ack_data_q,  ack_data_d;
   logic        ack_err_q,   ack_err_d;
   logic        write_q,     write_d;
   logic        mode_q,      mode_d;
   logic [1:0]  pulse_q,     pulse_d;
   logic [7:0]  byte1_q,     byte1_d;
   logic [7:0]  byte2_q,     byte2_d;

   logic        int_s;
   logic        int_req;
   logic        timer_load;
   logic        timer_gap;
   logic        timer_done;

`ifdef PIC_CPU_IF_INT_SYNC_EN
   logic [1:0] int_sync_q;

   // Two-flop synchronizer for the asynchronous INT pin.
   always_ff @(posedge clk) begin
      if (reset) begin
         int_sync_q <= '0;
      end else begin
         int_sync_q <= {int_sync_q[0], INT};
      end
   end

   assign int_s = int_sync_q[1];
`else
   assign int_s = INT;
`endif

   assign int_req   = int_s && int_ack_en;
   assign cmd_ready = (state_q == ST_IDLE) && !reset && !int_req;

   pic_strobe_timer #(
      .W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (timer_gap ? CNT_W'(GAP_CYCLES) : CNT_W'(STROBE_CYCLES)),
      .done     (timer_done)
   );

   // Next-state and next-output logic; outputs are registered with the state.
   always_comb begin
      state_d     = state_q;
      cs_n_d      = cs_n_q;
      rd_n_d      = rd_n_q;
      wr_n_d      = wr_n_q;
      inta_n_d    = inta_n_q;
      a0_d        = a0_q;
      data_out_d  = data_out_q;
      data_oe_d   = data_oe_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      ack_valid_d = 1'b0;
      ack_data_d  = ack_data_q;
      ack_err_d   = ack_err_q;
      write_d     = write_q;
      mode_d      = mode_q;
      pulse_d     = pulse_q;
      byte1_d     = byte1_q;
      byte2_d     = byte2_q;
      timer_load  = 1'b0;
      timer_gap   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // A pending interrupt wins over a simultaneous command.
            if (int_req) begin
               state_d    = ST_INTA_LOW;
               inta_n_d   = 1'b0;
               data_oe_d  = 1'b0;
               mode_d     = mode_8086;
               pulse_d    = 2'd0;
               timer_load = 1'b1;
            end else if (cmd_valid && cmd_ready) begin
               state_d   = ST_SETUP;
               cs_n_d    = 1'b0;
               a0_d      = cmd_a0;
               write_d   = cmd_write;
               data_oe_d = cmd_write;
               if (cmd_write) begin
                  data_out_d = cmd_data;
               end
            end
         end

         ST_SETUP: begin
            state_d    = ST_STROBE;
            wr_n_d     = !write_q;
            rd_n_d     = write_q;
            timer_load = 1'b1;
         end

         ST_STROBE: begin
            if (timer_done) begin
               state_d = ST_HOLD;
               wr_n_d  = 1'b1;
               rd_n_d  = 1'b1;
               if (!write_q) begin
                  rsp_data_d = data_in;
               end
            end
         end

         ST_HOLD: begin
            state_d     = ST_GAP;
            cs_n_d      = 1'b1;
            data_oe_d   = 1'b0;
            rsp_valid_d = !write_q;
            timer_load  = 1'b1;
            timer_gap   = 1'b1;
         end

         ST_GAP: begin
            if (timer_done) begin
               state_d = ST_IDLE;
            end
         end

         ST_INTA_LOW: begin
            if (timer_done) begin
               state_d    = ST_INTA_GAP;
               inta_n_d   = 1'b1;
               timer_load = 1'b1;
               timer_gap  = 1'b1;
               if (pulse_q == 2'd0) begin
                  byte1_d = data_in;
               end
               if (pulse_q == 2'd1) begin
                  byte2_d = data_in;
               end
               // Final pulse: the byte on the bus right now completes the vector.
               if (pulse_q == last_pulse_idx(mode_q)) begin
                  ack_valid_d = 1'b1;
                  if (mode_q) begin
                     ack_data_d = {8'h00, data_in};
                     ack_err_d  = 1'b0;
                  end else begin
                     ack_data_d = {data_in, byte2_q};
                     ack_err_d  = (byte1_q != CALL_OPCODE);
                  end
               end
            end
         end

         ST_INTA_GAP: begin
            if (timer_done) begin
               if (pulse_q == last_pulse_idx(mode_q)) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d    = ST_INTA_LOW;
                  inta_n_d   = 1'b0;
                  pulse_d    = pulse_q + 2'd1;
                  timer_load = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state and registered bus outputs; reset releases the bus on the next edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cs_n_q      <= 1'b1;
         rd_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         inta_n_q    <= 1'b1;
         a0_q        <= 1'b0;
         data_out_q  <= 8'h00;
         data_oe_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
         ack_valid_q <= 1'b0;
         ack_data_q  <= 16'h0000;
         ack_err_q   <= 1'b0;
         write_q     <= 1'b0;
         mode_q      <= 1'b0;
         pulse_q     <= 2'd0;
         byte1_q     <= 8'h00;
         byte2_q     <= 8'h00;
      end else begin
         state_q     <= state_d;
         cs_n_q      <= cs_n_d;
         rd_n_q      <= rd_n_d;
         wr_n_q      <= wr_n_d;
         inta_n_q    <= inta_n_d;
         a0_q        <= a0_d;
         data_out_q  <= data_out_d;
         data_oe_q   <= data_oe_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         ack_valid_q <= ack_valid_d;
         ack_data_q  <= ack_data_d;
         ack_err_q   <= ack_err_d;
         write_q     <= write_d;
         mode_q      <= mode_d;
         pulse_q     <= pulse_d;
         byte1_q     <= byte1_d;
         byte2_q     <= byte2_d;
      end
   end

   assign CS        = cs_n_q;
   assign RD        = rd_n_q;
   assign WR        = wr_n_q;
   assign INTA      = inta_n_q;
   assign A0        = a0_q;
   assign data_out  = data_out_q;
   assign data_oe   = data_oe_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign ack_valid = ack_valid_q;
   assign ack_data  = ack_data_q;
   assign ack_err   = ack_err_q;

endmodule

// File: tb/tb_pic_cpu_interface.sv
// Directed testbench for pic_cpu_interface (default build, no INT synchronizer).
// Expected read data and INTA vectors are queued when stimulus is driven and
// compared when the DUT pulses rsp_valid / ack_valid.
module tb_pic_cpu_interface;

   localparam int S = 2;
   localparam int G = 2;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic        cmd_a0;
   logic [7:0]  cmd_data;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic        int_ack_en;
   logic        mode_8086;
   logic        INT;
   logic        INTA;
   logic        RD;
   logic        WR;
   logic        CS;
   logic        A0;
   logic [7:0]  data_out;
   logic        data_oe;
   logic [7:0]  data_in;
   logic        ack_valid;
   logic [15:0] ack_data;
   logic        ack_err;

   int total = 0;
   int bad   = 0;

   logic [7:0]  rsp_q[$];
   logic [16:0] ack_q[$];

   pic_cpu_interface #(
      .STROBE_CYCLES (S),
      .GAP_CYCLES    (G)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_a0     (cmd_a0),
      .cmd_data   (cmd_data),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .int_ack_en (int_ack_en),
      .mode_8086  (mode_8086),
      .INT        (INT),
      .INTA       (INTA),
      .RD         (RD),
      .WR         (WR),
      .CS         (CS),
      .A0         (A0),
      .data_out   (data_out),
      .data_oe    (data_oe),
      .data_in    (data_in),
      .ack_valid  (ack_valid),
      .ack_data   (ack_data),
      .ack_err    (ack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [4:0] bus_obs();
      return {CS, WR, RD, INTA, data_oe};
   endfunction

   // Bus pins in cycle c after a command was accepted.
   function automatic logic [4:0] exp_cmd_bus(input int c, input logic wr);
      logic act;
      logic stb;
      act = (c >= 1) && (c <= 2 + S);
      stb = (c >= 2) && (c <= 1 + S);
      return {~act, ~(wr & stb), ~(~wr & stb), 1'b1, wr & act};
   endfunction

   // Bus pins in cycle c after an INTA sequence of n pulses was started.
   function automatic logic [4:0] exp_inta_bus(input int c, input int n);
      int   k;
      int   ph;
      logic low;
      k   = (c - 1) / (S + G);
      ph  = (c - 1) % (S + G);
      low = (c >= 1) && (k < n) && (ph < S);
      return {3'b111, ~low, 1'b0};
   endfunction

   // Advance one clock, sample 1 time unit after the edge, run the scoreboard.
   task automatic step();
      @(posedge clk);
      #1;
      if (rsp_valid) begin
         if (rsp_q.size() == 0) chk("rsp_unexpected", {63'b0, rsp_valid}, 64'd0);
         else                   chk("rsp_data", rsp_data, rsp_q.pop_front());
      end
      if (ack_valid) begin
         if (ack_q.size() == 0) chk("ack_unexpected", {63'b0, ack_valid}, 64'd0);
         else                   chk("ack_vector", {ack_err, ack_data}, ack_q.pop_front());
      end
   endtask

   // Cycles 1..3+S+G of an accepted command; ends in the cycle cmd_ready returns.
   task automatic cmd_cycles(input logic wr, input logic a0, input logic [7:0] wdata);
      for (int c = 1; c <= 3 + S + G; c++) begin
         chk($sformatf("cmd_bus_c%0d", c), bus_obs(), exp_cmd_bus(c, wr));
         if (c <= 2 + S) chk($sformatf("cmd_a0_c%0d", c), A0, a0);
         if (wr && c <= 2 + S) chk($sformatf("cmd_data_out_c%0d", c), data_out, wdata);
         chk($sformatf("cmd_rsp_valid_c%0d", c), rsp_valid, (!wr && c == 3 + S));
         chk($sformatf("cmd_ready_c%0d", c), cmd_ready, (c == 3 + S + G));
         if (c < 3 + S + G) step();
      end
   endtask

   task automatic issue_cmd(input logic wr, input logic a0, input logic [7:0] wdata,
                            input logic [7:0] rdata);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_a0    = a0;
      cmd_data  = wdata;
      data_in   = rdata;
      #1;
      chk("cmd_ready_before_accept", cmd_ready, 1'b1);
      if (!wr) rsp_q.push_back(rdata);
      step();
      cmd_valid = 1'b0;
      cmd_data  = 8'h00;
      cmd_cycles(wr, a0, wdata);
   endtask

   // Cycles 1..n(S+G)+1 of an INTA sequence, presenting one byte per pulse.
   task automatic inta_cycles(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2);
      int last;
      int ack_c;
      int k;
      last  = n * (S + G) + 1;
      ack_c = S + (n - 1) * (S + G) + 1;
      for (int c = 1; c <= last; c++) begin
         k       = (c - 1) / (S + G);
         data_in = (k == 0) ? b0 : ((k == 1) ? b1 : b2);
         chk($sformatf("inta_bus_c%0d", c), bus_obs(), exp_inta_bus(c, n));
         chk($sformatf("inta_ack_valid_c%0d", c), ack_valid, (c == ack_c));
         chk($sformatf("inta_ready_c%0d", c), cmd_ready, (c == last));
         if (c < last) step();
      end
   endtask

   task automatic issue_inta(input logic mode, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2);
      int_ack_en = 1'b1;
      INT        = 1'b1;
      mode_8086  = mode;
      #1;
      chk("inta_ready_blocked", cmd_ready, 1'b0);
      if (mode) ack_q.push_back({1'b0, 8'h00, b1});
      else      ack_q.push_back({(b0 != 8'hCD), b2, b1});
      step();
      // INT drops and the mode input flips: the sequence must still finish as latched.
      INT       = 1'b0;
      mode_8086 = ~mode;
      inta_cycles(mode ? 2 : 3, b0, b1, b2);
   endtask

   initial begin
      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_write  = 1'b0;
      cmd_a0     = 1'b0;
      cmd_data   = 8'h00;
      int_ack_en = 1'b0;
      mode_8086  = 1'b0;
      INT        = 1'b0;
      data_in    = 8'h00;

      // Reset state.
      repeat (3) step();
      chk("reset_outputs",
          {CS, WR, RD, INTA, A0, data_oe, data_out, rsp_valid, rsp_data,
           ack_valid, ack_data, ack_err, cmd_ready},
          {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00,
           1'b0, 16'h0000, 1'b0, 1'b0});
      reset = 1'b0;
      step();

      // ICW1 write, then status read.
      issue_cmd(1'b1, 1'b0, 8'h36, 8'h00);
      issue_cmd(1'b0, 1'b1, 8'h00, 8'h5A);

      // INTA sequences: 8086 two-pulse, 8080 three-pulse good and bad opcode.
      issue_inta(1'b1, 8'hFF, 8'h20, 8'h00);
      issue_inta(1'b0, 8'hCD, 8'h40, 8'h12);
      issue_inta(1'b0, 8'h00, 8'h40, 8'h12);

      // INT ignored while int_ack_en is low.
      int_ack_en = 1'b0;
      INT        = 1'b1;
      issue_cmd(1'b0, 1'b0, 8'h00, 8'hC3);
      INT        = 1'b0;

      // INT and a command arrive together: INTA first, then the command.
      int_ack_en = 1'b1;
      INT        = 1'b1;
      mode_8086  = 1'b1;
      cmd_valid  = 1'b1;
      cmd_write  = 1'b1;
      cmd_a0     = 1'b1;
      cmd_data   = 8'hA5;
      #1;
      chk("simul_ready_blocked", cmd_ready, 1'b0);
      ack_q.push_back({1'b0, 8'h00, 8'h77});
      step();
      INT = 1'b0;
      inta_cycles(2, 8'h11, 8'h77, 8'h00);
      step();
      cmd_valid = 1'b0;
      cmd_data  = 8'h00;
      cmd_cycles(1'b1, 1'b1, 8'hA5);

      // Reset during the second strobe clock of a write.
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_a0    = 1'b0;
      cmd_data  = 8'h99;
      #1;
      chk("abort_wr_ready", cmd_ready, 1'b1);
      step();
      cmd_valid = 1'b0;
      step();
      step();
      chk("abort_wr_in_strobe", WR, 1'b0);
      reset = 1'b1;
      step();
      chk("abort_wr_bus", bus_obs(), 5'b11110);
      chk("abort_wr_ready_in_reset", cmd_ready, 1'b0);
      reset = 1'b0;
      #1;
      chk("abort_wr_ready_after", cmd_ready, 1'b1);

      // Reset during a read strobe: no response may appear.
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      data_in   = 8'hEE;
      step();
      cmd_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("abort_rd_no_rsp_%0d", i), rsp_valid, 1'b0);
         step();
      end
      chk("abort_rd_ready", cmd_ready, 1'b1);

      chk("rsp_queue_drained", rsp_q.size(), 0);
      chk("ack_queue_drained", ack_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
